// File: rtl/fxp_pack_buffer.sv
// fxp_pack_buffer
//   Packs LANES consecutive W-bit fixed-point samples, LSB lane first, into a
//   single word. Completed or flushed words go into a DEPTH-word show-ahead
//   FIFO that drives a ready/valid stream. The upstream source cannot be
//   stalled, so a push into a full FIFO is dropped unless a pop happens on
//   the same edge. Saturating counters track overflowed samples and dropped
//   words.
// Ports:
//   clk, rstn              clock (rising edge), async active-low reset
//   in_data/in_valid       sample stream from float2fxp_pipe
//   in_overflow            sample was saturated upstream
//   flush                  one-cycle pulse: emit the partial word
//   out_data/out_keep      FIFO head word and its lane-valid mask
//   out_ovf                OR of in_overflow over the head word's lanes
//   out_valid/out_ready    output handshake, pop on valid && ready
//   ovf_cnt, drop_cnt      saturating statistics
module fxp_pack_buffer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  input  logic                 in_overflow,
  input  logic                 flush,
  output logic [W*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_keep,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        ovf_cnt,
  output logic [CW-1:0]        drop_cnt
);
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = W * LANES;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  // pack stage
  logic [LW-1:0]    r_lane_idx;
  logic [DW-1:0]    r_pack;
  logic [LANES-1:0] r_keep;
  logic             r_ovf;
  logic [DW-1:0]    w_pack_nxt;
  logic [LANES-1:0] w_keep_nxt;
  logic             w_ovf_nxt;
  logic             w_push;

  // The incoming sample is merged first, so a flush on the same cycle
  // emits a word that already contains it, and a completing sample plus
  // flush still yields a single push.
  always_comb begin
    w_pack_nxt = r_pack;
    w_keep_nxt = r_keep;
    w_ovf_nxt  = r_ovf;
    if (in_valid) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (r_lane_idx == LW'(k)) begin
          w_pack_nxt[k*W +: W] = in_data;
          w_keep_nxt[k]        = 1'b1;
        end
      end
      w_ovf_nxt = r_ovf | in_overflow;
    end
    w_push = (in_valid && (r_lane_idx == LAST_LANE)) ||
             (flush && ((r_lane_idx != '0) || in_valid));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane_idx <= '0;
      r_pack     <= '0;
      r_keep     <= '0;
      r_ovf      <= 1'b0;
    end else if (w_push) begin
      r_lane_idx <= '0;
      r_pack     <= '0;
      r_keep     <= '0;
      r_ovf      <= 1'b0;
    end else if (in_valid) begin
      r_lane_idx <= r_lane_idx + LW'(1);
      r_pack     <= w_pack_nxt;
      r_keep     <= w_keep_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // FIFO stage
  logic [DW-1:0]    r_mem_data [DEPTH];
  logic [LANES-1:0] r_mem_keep [DEPTH];
  logic             r_mem_ovf  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_wr_en;
  logic             w_drop;
  logic [AW:0]      w_count_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [DW-1:0]    w_head_data;
  logic [LANES-1:0] w_head_keep;
  logic             w_head_ovf;

  // The output registers hold a copy of the head. When the FIFO is empty
  // after any pop, the word being written becomes the new head directly.
  always_comb begin
    w_pop       = out_valid && out_ready;
    w_wr_en     = w_push && ((r_count != FULL_CNT) || w_pop);
    w_drop      = w_push && (r_count == FULL_CNT) && !w_pop;
    w_count_nxt = r_count + (AW + 1)'(w_wr_en) - (AW + 1)'(w_pop);
    w_rd_nxt    = r_rd_ptr + AW'(w_pop);
    w_head_data = '0;
    w_head_keep = '0;
    w_head_ovf  = 1'b0;
    if (w_count_nxt != '0) begin
      if ((r_count - (AW + 1)'(w_pop)) == '0) begin
        w_head_data = w_pack_nxt;
        w_head_keep = w_keep_nxt;
        w_head_ovf  = w_ovf_nxt;
      end else begin
        w_head_data = r_mem_data[w_rd_nxt];
        w_head_keep = r_mem_keep[w_rd_nxt];
        w_head_ovf  = r_mem_ovf[w_rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr] <= w_pack_nxt;
      r_mem_keep[r_wr_ptr] <= w_keep_nxt;
      r_mem_ovf[r_wr_ptr]  <= w_ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_count_nxt;
      out_valid <= (w_count_nxt != '0);
      out_data  <= w_head_data;
      out_keep  <= w_head_keep;
      out_ovf   <= w_head_ovf;
    end
  end

  // statistics
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (in_valid && in_overflow && (ovf_cnt != CNT_MAX)) ovf_cnt <= ovf_cnt + CW'(1);
      if (w_drop && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fxp_pack_buffer.sv
module tb_fxp_pack_buffer;
  localparam int unsigned W     = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned DW    = W * LANES;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_overflow = 1'b0;
  logic             flush = 1'b0;
  logic [DW-1:0]    out_data;
  logic [LANES-1:0] out_keep;
  logic             out_ovf;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    ovf_cnt;
  logic [CW-1:0]    drop_cnt;

  fxp_pack_buffer #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_overflow(in_overflow), .flush(flush), .out_data(out_data),
    .out_keep(out_keep), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: pending samples in a queue, words in a queue.
  typedef struct {
    logic [DW-1:0]    d;
    logic [LANES-1:0] k;
    logic             o;
  } word_t;

  word_t        fq[$];
  logic [W-1:0] cur[$];
  logic         cur_o;
  int unsigned  m_ovf, m_drop;
  bit           m_pop, m_emit;
  word_t        m_w;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      cur.delete();
      cur_o  = 1'b0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      m_pop = (fq.size() > 0) && out_ready;
      if (in_valid) begin
        cur.push_back(in_data);
        if (in_overflow) begin
          cur_o = 1'b1;
          if (m_ovf < CMAX) m_ovf++;
        end
      end
      m_emit = (cur.size() == LANES) || (flush && cur.size() > 0);
      if (m_pop) void'(fq.pop_front());
      if (m_emit) begin
        m_w.d = '0;
        m_w.k = '0;
        for (int i = 0; i < cur.size(); i++) begin
          m_w.d[i*W +: W] = cur[i];
          m_w.k[i]        = 1'b1;
        end
        m_w.o = cur_o;
        if (fq.size() < DEPTH) fq.push_back(m_w);
        else if (m_drop < CMAX) m_drop++;
        cur.delete();
        cur_o = 1'b0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      chk("out_valid", 64'(out_valid), 64'(fq.size() > 0));
      if (fq.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(fq[0].d));
        chk("out_keep", 64'(out_keep), 64'(fq[0].k));
        chk("out_ovf",  64'(out_ovf),  64'(fq[0].o));
      end
      chk("ovf_cnt",  64'(ovf_cnt),  64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  task automatic send(input logic [W-1:0] d, input logic o, input logic f);
    in_data = d; in_valid = 1'b1; in_overflow = o; flush = f;
    @(negedge clk);
    in_valid = 1'b0; in_overflow = 1'b0; flush = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    for (int i = 0; i < LANES; i++) send(d, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  logic [W-1:0]  b;
  logic [DW-1:0] e;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data",  64'(out_data),  64'h0);
    chk("rst_keep",  64'(out_keep),  64'h0);
    chk("rst_cnt",   64'({ovf_cnt, drop_cnt}), 64'h0);
    rstn = 1'b1;
    @(negedge clk);

    // basic packing
    out_ready = 1'b1;
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 0, 0);
    chk("basic_valid", 64'(out_valid), 64'h1);
    chk("basic_data",  64'(out_data),  64'h04030201);
    chk("basic_keep",  64'(out_keep),  64'hF);
    chk("basic_ovf",   64'(out_ovf),   64'h0);
    @(negedge clk);
    chk("basic_once",  64'(out_valid), 64'h0);

    // partial flush, then empty flush
    send(8'hAA, 0, 0); send(8'hBB, 0, 0);
    do_flush();
    chk("pflush_valid", 64'(out_valid), 64'h1);
    chk("pflush_data",  64'(out_data),  64'h0000BBAA);
    chk("pflush_keep",  64'(out_keep),  64'h3);
    @(negedge clk);
    chk("pflush_once",  64'(out_valid), 64'h0);
    do_flush();
    chk("eflush_none",  64'(out_valid), 64'h0);
    @(negedge clk);
    chk("eflush_none2", 64'(out_valid), 64'h0);

    // flush together with a completing sample
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0); send(8'h44, 0, 1);
    chk("cflush_data", 64'(out_data), 64'h44332211);
    chk("cflush_keep", 64'(out_keep), 64'hF);
    @(negedge clk);
    chk("cflush_once", 64'(out_valid), 64'h0);
    send(8'h01, 0, 0); send(8'h02, 0, 0); send(8'h03, 0, 0); send(8'h04, 0, 0);
    chk("cflush_lane0", 64'(out_data), 64'h04030201);

    // overflow tracking
    send(8'h7F, 1, 0); send(8'h05, 0, 0); send(8'h80, 1, 0); send(8'h06, 0, 0);
    chk("ovf_data", 64'(out_data), 64'h0680057F);
    chk("ovf_flag", 64'(out_ovf),  64'h1);
    chk("ovf_cnt2", 64'(ovf_cnt),  64'h2);
    @(negedge clk);

    // backpressure and drop
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_word(b);
    end
    chk("bp_drop1", 64'(drop_cnt), 64'h1);
    repeat (3) @(negedge clk);
    chk("bp_hold", 64'(out_data), 64'h01010101);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      e = {LANES{b}};
      chk("bp_drain", 64'(out_data), 64'(e));
      @(negedge clk);
    end
    chk("bp_empty", 64'(out_valid), 64'h0);

    // full FIFO with a pop coinciding with the push
    out_ready = 1'b0;
    for (int i = 6; i <= 9; i++) begin
      b = 8'(i);
      send_word(b);
    end
    send(8'h0A, 0, 0); send(8'h0A, 0, 0); send(8'h0A, 0, 0);
    out_ready = 1'b1;
    send(8'h0A, 0, 0);
    chk("pp_nodrop", 64'(drop_cnt), 64'h1);
    for (int i = 7; i <= 10; i++) begin
      b = 8'(i);
      e = {LANES{b}};
      chk("pp_drain", 64'(out_data), 64'(e));
      @(negedge clk);
    end
    chk("pp_empty", 64'(out_valid), 64'h0);

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b = 8'(8'h30 + i);
      send_word(b);
    end
    send(8'hE1, 0, 0); send(8'hE2, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_ovf",   64'(ovf_cnt),   64'h0);
    chk("mrst_drop",  64'(drop_cnt),  64'h0);
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(8'hC1, 0, 0); send(8'hC2, 0, 0); send(8'hC3, 0, 0); send(8'hC4, 0, 0);
    chk("mrst_fresh", 64'(out_data), 64'hC4C3C2C1);
    chk("mrst_keep",  64'(out_keep), 64'hF);
    @(negedge clk);

    // randomized traffic with bursts of backpressure
    for (int blk = 0; blk < 15; blk++) begin
      automatic int unsigned rdy_pct = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        in_data     = 8'($urandom);
        in_valid    = ($urandom_range(0, 3) != 0);
        in_overflow = ($urandom_range(0, 4) == 0);
        flush       = ($urandom_range(0, 9) == 0);
        out_ready   = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    chk("final_empty", 64'(out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
